// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x32 architectural register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes).
package regfile_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // Index 0 is the hardwired zero register; it never stores or forwards data.
  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_32_bits.sv
// Single 32-bit storage register with load enable and asynchronous active-low clear.
// Latency: d appears on q one clk edge after en is sampled high.
// Backpressure: none; a load is accepted on every enabled edge.
module register_32_bits
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  word_t d,
  output word_t q
);

  // Load d when enabled; reset clears regardless of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port, r0 = 0.
// Latency: reads zero-cycle; writes visible after the rising edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; one write and two reads accepted every cycle. Optional macro: REGFILE_BYPASS_EN.
module register_file_32x32
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  word_t                  regs [REG_COUNT];
  logic [REG_COUNT-1:1]   wen;

  // One-hot write decode gated by we; an unknown waddr matches no index so nothing is written.
  always_comb begin
    wen = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (we && (waddr == reg_idx_t'(i))) begin
        wen[i] = 1'b1;
      end
    end
  end

  // Index 0 is a constant; indices 1..31 are real storage.
  assign regs[0] = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    register_32_bits u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wen[g]),
      .d     (wdata),
      .q     (regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  // Forwarding only for a live, non-zero write; reset keeps both ports at zero.
  assign fwd_ok = rst_n && we && !is_zero_reg(waddr);
`endif

  // Two 32:1 selects; the optional forward overrides the stored value on an index match.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (raddr1 == waddr)) rdata1 = wdata;
    if (fwd_ok && (raddr2 == waddr)) rdata2 = wdata;
`endif
  end

  // A write with an unknown target index is dropped by the decode; flag it in simulation.
  a_waddr_known : assert property (@(posedge clk) disable iff (!rst_n) we |-> !$isunknown(waddr));

endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench for register_file_32x32: directed cases plus randomized traffic vs a array model.
// Latency: reads checked mid-cycle (negedge) against the pre-edge architectural state.
// Backpressure: none; build with +define+REGFILE_BYPASS_EN to check the forwarding variant.
module tb_register_file_32x32;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk;
  logic     rst_n;
  logic     we;
  reg_idx_t waddr;
  word_t    wdata;
  reg_idx_t raddr1;
  reg_idx_t raddr2;
  word_t    rdata1;
  word_t    rdata2;

  register_file_32x32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    word_t e1;
    word_t e2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  word_t model [REG_COUNT];
  logic  chk_vld;
  int    n_checks;
  int    n_pass;

  function automatic void compare(input string nm, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  // Architectural read: r0 is zero, optional same-cycle forward of a live write.
  function automatic word_t exp_rd(input reg_idx_t a, input logic w, input reg_idx_t wa, input word_t wd);
    if (a == 0) return '0;
    if (BYP && rst_n && w && wa != 0 && a == wa) return wd;
    return model[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
  endfunction

  // Monitor: pops one expectation per flagged cycle and compares both ports.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare({nm, "_rdata1"}, rdata1, e.e1);
        compare({nm, "_rdata2"}, rdata2, e.e2);
      end
    end
  end

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input logic w, input reg_idx_t wa, input word_t wd,
                       input reg_idx_t a1, input reg_idx_t a2,
                       input bit chk, input word_t e1, input word_t e2, input string nm);
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = a1;
    raddr2 = a2;
    chk_vld = chk;
    if (chk) begin
      exp_q.push_back('{e1: e1, e2: e2});
      name_q.push_back(nm);
    end
    @(posedge clk);
    if (!rst_n) model_clear();
    else if (w && wa != 0) model[wa] = wd;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    chk_vld  = 1'b0;
    rst_n    = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr1   = '0;
    raddr2   = '0;
    model_clear();
    @(posedge clk);
    #1;

    // Reset state, with a write presented that must not land.
    drive(1'b1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd31, 1'b1, 32'h0, 32'h0, "reset_state");
    rst_n = 1'b1;

    // Write reg5, then assert reset mid-cycle and check it clears with no clock edge.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1,
          BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, "wr5_pre");
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, "rd5");
    #1;
    rst_n = 1'b0;
    model_clear();
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    chk_vld = 1'b1;
    exp_q.push_back('{e1: 32'h0, e2: 32'h0});
    name_q.push_back("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic write, then we=0 must hold the value.
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "wr7");
    drive(1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7, 1'b1, 32'h1234_5678, 32'h1234_5678, "we0_hold");
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 32'h1234_5678, 32'h0, "rd7_after");

    // Writes to r0 are discarded, even with forwarding.
    drive(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "wr0_pre");
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "rd0_after");

    // Same-cycle read/write on reg3.
    drive(1'b1, 5'd3, 32'h0000_0011, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "");
    drive(1'b1, 5'd3, 32'h0000_0022, 5'd3, 5'd3, 1'b1,
          BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, "rw3_same");
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 32'h22, 32'h22, "rd3_after");

    // Sweep: reg[i] = i*0x01010101, then read pairs (i, 31-i).
    for (int i = 1; i < REG_COUNT; i++)
      drive(1'b1, reg_idx_t'(i), word_t'(i) * 32'h0101_0101, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "");
    for (int i = 0; i < REG_COUNT; i++)
      drive(1'b0, 5'd0, 32'h0, reg_idx_t'(i), reg_idx_t'(31 - i), 1'b1,
            word_t'(i) * 32'h0101_0101, word_t'(31 - i) * 32'h0101_0101, "sweep");
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd0, 1'b1, 32'h1F1F_1F1F, 32'h0, "sweep_r31");

    // Reset asserted in the same cycle as a write to reg9.
    rst_n = 1'b0;
    model_clear();
    drive(1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd9, 1'b1, 32'h0, 32'h0, "rst_wr_in");
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 1'b1, 32'h0, 32'h0, "rst_wr_after");

    // Randomized traffic against the array model, biased toward read/write collisions.
    for (int n = 0; n < 400; n++) begin
      logic     w;
      reg_idx_t wa, a1, a2;
      word_t    wd;
      w  = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(w, wa, wd, a1, a2, 1'b1, exp_rd(a1, w, wa, wd), exp_rd(a2, w, wa, wd), "rand");
    end

    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "");
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- Architectural general-purpose register file of the single-cycle processor.
- Sits directly downstream of the write-back select (mux_2_for_32_bits choosing ALU result vs memory data) and consumes its 32-bit result as write data.
- Two asynchronous read ports feed the ALU operand path.
- One synchronous write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register index width.
- REG_COUNT, 32, number of registers; always equals 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  5  write register index.
- wdata  input  32  write data (write-back mux result).
- raddr1  input  5  read port 1 index.
- raddr2  input  5  read port 2 index.
- rdata1  output  32  read port 1 data, combinational.
- rdata2  output  32  read port 2 data, combinational.

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers to 32'h0000_0000, independent of clk.
  - rdata1 and rdata2 are therefore 0 while in reset.
  - Deassertion is synchronised outside this block; the first write is honoured on the first rising edge with rst_n high.
- Write: on rising clk with rst_n high and we=1, reg[waddr] <= wdata.
  - Exactly one register is updated per cycle.
  - we=0 leaves all registers unchanged.
- Register 0: writes with waddr=0 are discarded. Reads of index 0 always return 0.
- Read: rdata1 = reg[raddr1] and rdata2 = reg[raddr2], combinational, zero-cycle latency.
  - Both ports may address the same register; both return the same value.
- Read/write same cycle, same index, without bypass: the read returns the pre-edge (old) value. The new value is visible after the rising edge.
- Reset mid-write: rst_n low wins. A write presented in the same cycle as reset assertion is lost and the register reads 0.
- Arithmetic: none; no sign extension. Full 32-bit values are stored verbatim.
- X handling: if we=1 and waddr is unknown, no register is written (simulation assertion flags it).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When we=1, waddr!=0 and raddrN==waddr, rdataN = wdata combinationally in the same cycle. This lets a same-cycle producer/consumer see the new value.
- Undefined: no forwarding; read returns the stored value as specified above.
- The register 0 rule holds in both modes: raddr=0 always returns 0, even when forwarding.

Decomposition:
- Shared package regfile_pkg:
  - constants DATA_W=32, ADDR_W=5, REG_COUNT=32, ZERO_REG=5'd0.
  - typedef reg_idx_t (5-bit index) and word_t (32-bit data).
- One natural sub-module: register_32_bits, a single 32-bit D register with enable and async active-low clear.
  - Instantiated 31 times (indices 1..31).
  - Index 0 is tied to constant zero.
- Write enables come from a 5-to-32 one-hot decode of waddr gated by we.
- Read selection is two 32:1 32-bit selects, built from the existing mux_2_for_32_bits tree or an equivalent.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing reg5=32'hDEAD_BEEF -> rdata1 with raddr1=5 becomes 0 immediately, without a clock edge.
- Basic write/read: we=1, waddr=7, wdata=32'h1234_5678, one edge -> raddr1=7 gives 32'h1234_5678. Then we=0 with wdata=32'hFFFF_FFFF, one edge -> still 32'h1234_5678.
- Zero register: we=1, waddr=0, wdata=32'hA5A5_A5A5 -> raddr1=0 and raddr2=0 both read 0 after the edge.
- Same-cycle read/write on reg3 (old value 32'h0000_0011, wdata 32'h0000_0022):
  - Bypass off: reads 32'h11 before the edge, 32'h22 after.
  - Bypass on: reads 32'h22 before the edge.
- Dual port and sweep: write reg[i]=i*32'h0101_0101 for i=1..31, then read all pairs (i, 31-i) -> both ports return the expected values. Index 0 returns 0 and index 31 returns 32'h1F1F_1F1F.
- Reset during write: assert rst_n=0 in the same cycle as we=1, waddr=9, wdata=32'h0BAD_F00D -> after release, reg9 reads 0.
